// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus: word type, arbiter state encoding and
// the address-map constants used by decoders downstream of the arbiter.
package mem_bus_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam word_t       IO_BASE           = 16'hC000;
  localparam word_t       VIDEO_BASE        = 16'hF82F;
  localparam int unsigned MIN_ACCESS_CYCLES = 2;  // one cycle per byte of a word

endpackage

// File: rtl/memory_arbiter_if.sv
// Per-master word port: req/we/addr/wdata held by the master until a one-cycle ack.
interface memory_arbiter_if;
  import mem_bus_pkg::*;

  logic  req;
  logic  we;
  word_t addr;
  word_t wdata;
  word_t rdata;
  logic  ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input grant picker: alternates on a tie, or favours master 0 when FIXED_PRIORITY.
module rr_arbiter2 #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,       // the current grant is being taken this cycle
  output logic       grant_valid,
  output logic       grant         // index of the winning master
);

  logic last_grant;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = FIXED_PRIORITY ? 1'b0 : ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    last_grant <= 1'b1;  // master 0 wins the first tie
    else if (accept && grant_valid) last_grant <= grant;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-master arbiter/sequencer for memory_controller: holds one enable for
// ACCESS_CYCLES, then spends one idle cycle that also carries the master's ack.
module memory_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES  = 3,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  memory_arbiter_if.slave m0,
  memory_arbiter_if.slave m1,
  output word_t           mc_address,
  output word_t           mc_data_in,
  input  word_t           mc_data_out,
  output logic            mc_read_en,
  output logic            mc_write_en
);

  if (ACCESS_CYCLES < MIN_ACCESS_CYCLES) begin : g_bad_access_cycles
    $error("memory_arbiter: ACCESS_CYCLES=%0d is below the two-byte minimum", ACCESS_CYCLES);
  end

  localparam int unsigned      CNT_W    = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             take, finish;
  logic             grant_valid, grant;
  logic             sel;  // master owning the transfer in flight
  word_t            gnt_addr, gnt_wdata;
  logic             gnt_we;

  rr_arbiter2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_pick (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         ({m1.req, m0.req}),
    .accept      (take),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign gnt_addr  = grant ? m1.addr  : m0.addr;
  assign gnt_wdata = grant ? m1.wdata : m0.wdata;
  assign gnt_we    = grant ? m1.we    : m0.we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          take      = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Enables, ack and rdata all come from flops; reset abandons any transfer silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel         <= 1'b0;
      mc_address  <= '0;
      mc_data_in  <= '0;
      mc_read_en  <= 1'b0;
      mc_write_en <= 1'b0;
      m0.ack      <= 1'b0;
      m1.ack      <= 1'b0;
      m0.rdata    <= '0;
      m1.rdata    <= '0;
    end else begin
      m0.ack <= finish && !sel;
      m1.ack <= finish &&  sel;
      if (take) begin
        sel         <= grant;
        mc_address  <= gnt_addr;
        mc_data_in  <= gnt_wdata;
        mc_read_en  <= !gnt_we;
        mc_write_en <= gnt_we;
      end else if (finish) begin
        mc_read_en  <= 1'b0;
        mc_write_en <= 1'b0;
        if (mc_read_en) begin
          if (sel) m1.rdata <= mc_data_out;
          else     m0.rdata <= mc_data_out;
        end
      end
    end
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Two-port arbiter and sequencer in front of memory_controller; shares its 16-bit word interface between master 0 (CPU) and master 1 (DMA/video fetch).
- Converts a per-master req/ack word handshake into the controller's level enable protocol. Holds read_en/write_en for a fixed byte-sequencing window, then forces one idle cycle so the controller's byte phase resets and the SRAM deselects.
- Sits between the CPU bus and memory_controller; downstream ports connect 1:1 to memory_controller address_in/data_in/data_out/read_en/write_en.

Parameters:
- ACCESS_CYCLES, 3, cycles read_en/write_en are held per word. Legal minimum is 2 (two bytes); values below 2 are an elaboration error.
- FIXED_PRIORITY, 0, 0 = round-robin between masters; 1 = master 0 always wins a tie.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 request (level)
- m0_we  in  1  master 0 write(1)/read(0)
- m0_addr  in  16  master 0 word address
- m0_wdata  in  16  master 0 write data
- m0_rdata  out  16  master 0 read data, valid with m0_ack on reads
- m0_ack  out  1  master 0 completion pulse, one cycle
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  as master 0
- mc_address  out  16  to memory_controller address_in
- mc_data_in  out  16  to memory_controller data_in
- mc_data_out  in  16  from memory_controller data_out
- mc_read_en  out  1  to memory_controller read_en
- mc_write_en  out  1  to memory_controller write_en

Behaviour:
- Reset state: all outputs are registered.
  - Reset values: mc_read_en=0, mc_write_en=0, mc_address=0, mc_data_in=0, m0/m1_ack=0, m0/m1_rdata=0, state=IDLE, cycle counter=0, last_grant=1 (master 0 wins the first tie).
- States:
  - IDLE: samples m0_req and m1_req.
    - If either is high, pick a winner, latch its addr/we/wdata into mc_address/mc_data_in, assert mc_read_en (we=0) or mc_write_en (we=1), load counter=ACCESS_CYCLES-1, go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS: exactly one enable high and mc_address/mc_data_in stable.
    - Counter decrements each cycle.
    - When counter==0: drop both enables, go to RELEASE.
    - The enable is high for exactly ACCESS_CYCLES consecutive cycles.
  - RELEASE: both enables low for one cycle.
    - Granted master's ack=1 this cycle.
    - On reads, mc_data_out is captured into that master's rdata on the edge entering RELEASE, so rdata is valid alongside ack.
    - Next state is always IDLE.
- Latency: request seen in IDLE at edge t → enables high t+1..t+ACCESS_CYCLES → ack cycle t+ACCESS_CYCLES+1 → IDLE. Word occupancy is ACCESS_CYCLES+2 cycles; default is 5.
- Handshake:
  - The master holds req/we/addr/wdata stable until it sees ack, then deasserts req on the next edge.
  - req still high in IDLE after an ack is a new request, so back-to-back transfers are legal.
  - Master inputs are ignored outside IDLE.
- Arbitration:
  - With one requester, that master is granted.
  - With both requesting: FIXED_PRIORITY=1 grants master 0. FIXED_PRIORITY=0 grants the master opposite last_grant.
  - last_grant updates on every grant.
- rdata holds its value until the next completed read for that master. Writes never alter rdata.
- Address decode (SRAM vs I/O vs video RAM above 0xF82F) is entirely memory_controller's job. The arbiter treats all addresses identically, including 0xC000–0xFFFF, with the same timing.
- Reset mid-operation: enables drop at once asynchronously, no ack is issued, and the in-flight transfer is abandoned. The master must reissue it.
- Only one enable is ever high. mc_read_en and mc_write_en are never high together and never high in IDLE or RELEASE.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding (IDLE, ACCESS, RELEASE)
  - the I/O base constant 16'hC000 and video base 16'hF82F, for the bench and later decoders
  - the minimum legal ACCESS_CYCLES value of 2
- One sub-module is natural: rr_arbiter2, a 2-input round-robin/fixed-priority grant picker with a last_grant register.
- The FSM, counter and datapath latches stay in memory_arbiter.

Test Plan:
- Single read, m0_req=1, m0_we=0, m0_addr=16'h0123, mc_data_out model returns 16'hBEEF → mc_read_en high exactly 3 cycles with mc_address=16'h0123, one idle cycle, m0_ack pulse with m0_rdata=16'hBEEF, total 5 cycles.
- Single write, m1 we=1, addr=16'hF830, wdata=16'h4141 → mc_write_en high 3 cycles with mc_data_in=16'h4141 and mc_address=16'hF830, then m1_ack, m1_rdata unchanged.
- Simultaneous m0/m1 reads with requests held after each ack, FIXED_PRIORITY=0 → grant order m0, m1, m0, m1. With FIXED_PRIORITY=1, m0 every time while held.
- Back-to-back m0 writes to 16'h0000 and 16'hBFFF → second enable rises exactly 2 cycles after the first falls, and the enables never overlap.
- Assert reset_n=0 in the 2nd ACCESS cycle → enables 0 immediately, no ack. After release the state is IDLE and the held request restarts with the full 3-cycle window.
- ACCESS_CYCLES=2 build → enable width 2, ack 3 cycles after the request is sampled.
